imm_extend_pipe: RTL and testbench
==================================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined immediate extender for the decode->execute path.
//  Takes an IMM_W-bit immediate field plus a 2-bit mode, produces a DATA_W-bit extended operand.
//  Result is registered with a valid/ready handshake and a one-entry skid buffer, so execute stalls never drop immediates.
//  Undefined modes are flagged and counted for debug.
// PARAMETERS
//  IMM_W      20  width of immediate field from decoder
//  DATA_W     32  width of extended operand; must satisfy DATA_W >= IMM_W + SHIFT_AMT
//  SEXT_LO_W  16  narrow sign-extension width (mode 01); must satisfy SEXT_LO_W <= IMM_W
//  SHIFT_AMT   2  left shift applied in mode 11 (branch word offset)
//  CNT_W       8  width of illegal-mode counter
// PORTS
//  clk_i         in   1          clock, rising edge
//  rst_i         in   1          asynchronous reset, active-high
//  in_valid_i    in   1          immediate/mode valid
//  in_ready_o    out  1          block can accept input this cycle
//  ext_sel_i     in   2          extension mode (ext_sel_e)
//  imm_i         in   IMM_W      immediate field
//  out_valid_o   out  1          imm_ext_o valid
//  out_ready_i   in   1          consumer accepts output
//  imm_ext_o     out  DATA_W     extended immediate
//  illegal_o     out  1          registered alongside imm_ext_o: mode was undefined
//  illegal_cnt_o out  CNT_W      saturating count of accepted illegal-mode transfers
// BEHAVIOUR
//  Reset: out_valid_o=0, imm_ext_o=0, illegal_o=0, illegal_cnt_o=0, skid empty, in_ready_o=1.
//  Modes: 00 zero-extend imm_i[IMM_W-1:0]; 01 sign-extend imm_i[SEXT_LO_W-1:0] from bit SEXT_LO_W-1
//   (upper imm bits ignored); 10 sign-extend imm_i from bit IMM_W-1; 11 see CONFIGURATION.
//  Transfer in: in_valid_i & in_ready_o. Transfer out: out_valid_o & out_ready_i.
//  Latency: 1 cycle; accepted input appears on outputs next cycle when output stage is empty or draining.
//  in_ready_o = ~skid_full, driven from a register only (no comb path from out_ready_i).
//  Output stall (out_valid_o & ~out_ready_i) + input transfer: result goes to skid; in_ready_o drops next cycle.
//  Skid full & out_ready_i: skid moves to output next cycle, in_ready_o returns to 1 same edge.
//  Output holds imm_ext_o/illegal_o stable while out_valid_o & ~out_ready_i.
//  Order preserved; no drops, no duplicates; throughput 1/cycle when out_ready_i stays high.
//  illegal_cnt_o increments on input transfer with illegal mode; saturates at 2^CNT_W-1, never wraps.
//  Inputs ignored when in_valid_i=0 or in_ready_o=0.
//  Reset mid-operation: in-flight output and skid entry discarded, counter cleared, in_ready_o=1.
// CONFIGURATION
//  IMM_EXT_SHIFT_MODE_EN defined: mode 11 = sign-extend imm_i from bit IMM_W-1, then << SHIFT_AMT
//   (low SHIFT_AMT bits zero), illegal_o=0.
//  Not defined: mode 11 is illegal: imm_ext_o=0, illegal_o=1, counter increments.
// STRUCTURE
//  Package imm_ext_pkg: typedef enum logic[1:0] ext_sel_e {EXT_ZERO, EXT_SIGN_LO, EXT_SIGN, EXT_SHIFT};
//   default parameter constants; width-legality check function used by elaboration asserts.
//  Sub-module imm_ext_core: purely combinational mode decode/extend (imm, sel -> ext, illegal);
//   imm_extend_pipe wraps it with output register, skid buffer and counter.
// TESTING
//  Reset then imm_i=20'h0_8001: sel 00 -> 32'h0000_8001; sel 01 -> 32'hFFFF_8001; sel 10 -> 32'h0000_8001, each 1 cycle later.
//  imm_i=20'h8_0000, sel 10 -> 32'hFFF8_0000; with _EN sel 11 -> 32'hFFE0_0000, illegal_o=0.
//  Without _EN, sel 11, imm_i=20'h1_2345 -> imm_ext_o=0, illegal_o=1, illegal_cnt_o 0->1; 300 such -> saturates at 8'hFF.
//  Stream A,B,C with out_ready_i low 2 cycles after A: in_ready_o drops after B skids; C held; outputs A,B,C in order, none lost.
//  out_ready_i held high, in_valid_i every cycle for 16 items -> 16 outputs on consecutive cycles, in_ready_o stays 1.
//  Assert rst_i asynchronously while skid full and out_valid_o=1 -> outputs zero immediately, in_ready_o=1, counter 0.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types, default widths and a parameter-legality helper for the immediate extender.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    EXT_ZERO    = 2'b00,
    EXT_SIGN_LO = 2'b01,
    EXT_SIGN    = 2'b10,
    EXT_SHIFT   = 2'b11
  } ext_sel_e;

  localparam int IMM_W_DEF     = 20;
  localparam int DATA_W_DEF    = 32;
  localparam int SEXT_LO_W_DEF = 16;
  localparam int SHIFT_AMT_DEF = 2;
  localparam int CNT_W_DEF     = 8;

  // True when the extended operand can hold the widest (shifted) result.
  function automatic bit widths_ok(input int imm_w, input int data_w,
                                   input int sext_lo_w, input int shift_amt);
    return (imm_w > 0) && (sext_lo_w > 0) && (sext_lo_w <= imm_w) &&
           (shift_amt >= 0) && (data_w >= imm_w + shift_amt);
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode->execute immediate bus: input handshake, output handshake and debug status.
interface imm_extend_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int IMM_W  = IMM_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        ext_sel_i;
  logic [IMM_W-1:0]  imm_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] imm_ext_o;
  logic              illegal_o;
  logic [CNT_W-1:0]  illegal_cnt_o;

  modport master (
    output in_valid_i, ext_sel_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, imm_ext_o, illegal_o, illegal_cnt_o
  );

  modport slave (
    input  in_valid_i, ext_sel_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, imm_ext_o, illegal_o, illegal_cnt_o
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational mode decode and extension of the immediate field.
// Mode 11 behaviour depends on IMM_EXT_SHIFT_MODE_EN (shifted sign-extend when defined, illegal otherwise).
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IMM_W     = IMM_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SEXT_LO_W = SEXT_LO_W_DEF,
  parameter int SHIFT_AMT = SHIFT_AMT_DEF
) (
  input  logic [IMM_W-1:0]  imm_i,
  input  ext_sel_e          sel_i,
  output logic [DATA_W-1:0] ext_o,
  output logic              illegal_o
);

  if (!widths_ok(IMM_W, DATA_W, SEXT_LO_W, SHIFT_AMT)) begin : g_bad_widths
    $error("imm_ext_core: illegal IMM_W/DATA_W/SEXT_LO_W/SHIFT_AMT combination");
  end

  logic signed [SEXT_LO_W-1:0] imm_lo;
  logic signed [IMM_W-1:0]     imm_s;

  assign imm_lo = imm_i[SEXT_LO_W-1:0];
  assign imm_s  = imm_i;

  always_comb begin
    ext_o     = '0;
    illegal_o = 1'b0;
    case (sel_i)
      EXT_ZERO:    ext_o = DATA_W'(imm_i);
      EXT_SIGN_LO: ext_o = DATA_W'(imm_lo);
      EXT_SIGN:    ext_o = DATA_W'(imm_s);
      EXT_SHIFT: begin
`ifdef IMM_EXT_SHIFT_MODE_EN
        ext_o = DATA_W'(imm_s) << SHIFT_AMT;
`else
        illegal_o = 1'b1;
`endif
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender with a one-entry skid buffer and saturating illegal-mode counter.
// Build option IMM_EXT_SHIFT_MODE_EN enables mode 11 (see imm_ext_core).
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IMM_W     = IMM_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SEXT_LO_W = SEXT_LO_W_DEF,
  parameter int SHIFT_AMT = SHIFT_AMT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  imm_extend_pipe_if.slave  bus
);

  logic [DATA_W-1:0] ext_c;
  logic              ill_c;
  logic              in_xfer;

  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_ill_q, out_ill_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_ill_q, skid_ill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  imm_ext_core #(
    .IMM_W    (IMM_W),
    .DATA_W   (DATA_W),
    .SEXT_LO_W(SEXT_LO_W),
    .SHIFT_AMT(SHIFT_AMT)
  ) u_core (
    .imm_i    (bus.imm_i),
    .sel_i    (ext_sel_e'(bus.ext_sel_i)),
    .ext_o    (ext_c),
    .illegal_o(ill_c)
  );

  // Ready comes straight from the skid flag so upstream never sees out_ready_i combinationally.
  assign in_xfer = bus.in_valid_i & ~skid_vld_q;

  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_ill_d   = out_ill_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_ill_d  = skid_ill_q;
    cnt_d       = cnt_q;

    if (skid_vld_q) begin
      // Skid only fills while the output is stalled, so out_vld_q is already 1 here.
      if (bus.out_ready_i) begin
        out_data_d = skid_data_q;
        out_ill_d  = skid_ill_q;
        skid_vld_d = 1'b0;
      end
    end else if (!out_vld_q || bus.out_ready_i) begin
      out_vld_d = in_xfer;
      if (in_xfer) begin
        out_data_d = ext_c;
        out_ill_d  = ill_c;
      end
    end else if (in_xfer) begin
      skid_vld_d  = 1'b1;
      skid_data_d = ext_c;
      skid_ill_d  = ill_c;
    end

    if (in_xfer && ill_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_ill_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ill_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_ill_q   <= out_ill_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_ill_q  <= skid_ill_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready_o    = ~skid_vld_q;
  assign bus.out_valid_o   = out_vld_q;
  assign bus.imm_ext_o     = out_data_q;
  assign bus.illegal_o     = out_ill_q;
  assign bus.illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed vectors, handshake corner cases and random traffic
// checked against a queue-based reference model.
module tb_imm_extend_pipe;

  localparam int IMM_W     = 20;
  localparam int DATA_W    = 32;
  localparam int SEXT_LO_W = 16;
  localparam int SHIFT_AMT = 2;
  localparam int CNT_W     = 8;

  typedef struct {
    logic [1:0]        sel;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] exp_ext;
    logic              exp_ill;
  } vec_t;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              il;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imm_extend_pipe_if #(.IMM_W(IMM_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  imm_extend_pipe #(
    .IMM_W    (IMM_W),
    .DATA_W   (DATA_W),
    .SEXT_LO_W(SEXT_LO_W),
    .SHIFT_AMT(SHIFT_AMT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  int    n_out  = 0;
  int    mcnt   = 0;
  item_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  // Reference extension by plain integer arithmetic.
  function automatic item_t ref_ext(input logic [1:0] s, input logic [IMM_W-1:0] v);
    longint x;
    item_t  r;
    r.il = 1'b0;
    x    = longint'(v);
    case (s)
      2'd0: ;
      2'd1: begin
        x = x % (longint'(1) << SEXT_LO_W);
        if (x >= (longint'(1) << (SEXT_LO_W - 1))) x = x - (longint'(1) << SEXT_LO_W);
      end
      2'd2: begin
        if (x >= (longint'(1) << (IMM_W - 1))) x = x - (longint'(1) << IMM_W);
      end
      default: begin
`ifdef IMM_EXT_SHIFT_MODE_EN
        if (x >= (longint'(1) << (IMM_W - 1))) x = x - (longint'(1) << IMM_W);
        x = x * (longint'(1) << SHIFT_AMT);
`else
        x    = 0;
        r.il = 1'b1;
`endif
      end
    endcase
    r.d = x[DATA_W-1:0];
    return r;
  endfunction

  // One clock: model the handshake from occupancy, then compare all outputs.
  task automatic tick(input string nm);
    logic        in_x, out_x;
    item_t       it;
    logic [63:0] act, exp;
    in_x  = bus.in_valid_i && (mq.size() < 2);
    out_x = (mq.size() > 0) && bus.out_ready_i;
    it    = ref_ext(bus.ext_sel_i, bus.imm_i);
    @(posedge clk);
    if (out_x) begin
      void'(mq.pop_front());
      n_out++;
    end
    if (in_x) begin
      mq.push_back(it);
      if (it.il && (mcnt < (1 << CNT_W) - 1)) mcnt++;
    end
    #1;
    if (mq.size() > 0)
      exp = {21'b0, 1'b1, 1'b1, mq[0].il, CNT_W'(mcnt), mq[0].d};
    else
      exp = {21'b0, 1'b1, 1'b0, 1'b0, CNT_W'(mcnt), {DATA_W{1'b0}}};
    if (mq.size() == 2) exp[42] = 1'b0;
    act = {21'b0, bus.in_ready_o, bus.out_valid_o,
           bus.out_valid_o ? bus.illegal_o : 1'b0, bus.illegal_cnt_o,
           bus.out_valid_o ? bus.imm_ext_o : {DATA_W{1'b0}}};
    chk(nm, act, exp);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [IMM_W-1:0] i, input logic r);
    bus.in_valid_i  = v;
    bus.ext_sel_i   = s;
    bus.imm_i       = i;
    bus.out_ready_i = r;
  endtask

  vec_t tbl[9];

  initial begin
    drive(1'b0, 2'd0, '0, 1'b0);

    tbl[0] = '{2'b00, 20'h08001, 32'h0000_8001, 1'b0};
    tbl[1] = '{2'b01, 20'h08001, 32'hFFFF_8001, 1'b0};
    tbl[2] = '{2'b10, 20'h08001, 32'h0000_8001, 1'b0};
    tbl[3] = '{2'b10, 20'h80000, 32'hFFF8_0000, 1'b0};
`ifdef IMM_EXT_SHIFT_MODE_EN
    tbl[4] = '{2'b11, 20'h80000, 32'hFFE0_0000, 1'b0};
    tbl[5] = '{2'b11, 20'h12345, 32'h0004_8D14, 1'b0};
`else
    tbl[4] = '{2'b11, 20'h80000, 32'h0000_0000, 1'b1};
    tbl[5] = '{2'b11, 20'h12345, 32'h0000_0000, 1'b1};
`endif
    tbl[6] = '{2'b01, 20'hF7FFF, 32'h0000_7FFF, 1'b0};
    tbl[7] = '{2'b00, 20'hFFFFF, 32'h000F_FFFF, 1'b0};
    tbl[8] = '{2'b10, 20'h7FFFF, 32'h0007_FFFF, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",
        {24'b0, bus.out_valid_o, bus.illegal_o, bus.in_ready_o, bus.illegal_cnt_o, bus.imm_ext_o},
        {24'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0});
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tbl[i].sel, tbl[i].imm, 1'b1);
      tick($sformatf("vec%0d_model", i));
      bus.in_valid_i = 1'b0;
      chk($sformatf("vec%0d", i),
          {30'b0, bus.out_valid_o, bus.illegal_o, bus.imm_ext_o},
          {30'b0, 1'b1, tbl[i].exp_ill, tbl[i].exp_ext});
    end
    tick("vec_drain");
`ifdef IMM_EXT_SHIFT_MODE_EN
    chk("vec_cnt", 64'(bus.illegal_cnt_o), 64'd0);
`else
    chk("vec_cnt", 64'(bus.illegal_cnt_o), 64'd2);
`endif

    // A, B, C with a two-cycle stall after A.
    drive(1'b1, 2'd0, 20'h11111, 1'b1);
    tick("abc_a");
    drive(1'b1, 2'd1, 20'h0ABCD, 1'b0);
    tick("abc_b");
    chk("abc_ready_drop", 64'(bus.in_ready_o), 64'd0);
    drive(1'b1, 2'd2, 20'hFFFFF, 1'b0);
    tick("abc_stall");
    chk("abc_hold_a", {31'b0, bus.out_valid_o, bus.imm_ext_o}, {31'b0, 1'b1, 32'h0001_1111});
    bus.out_ready_i = 1'b1;
    tick("abc_release");
    chk("abc_out_b", {31'b0, bus.in_ready_o, bus.imm_ext_o}, {31'b0, 1'b1, 32'hFFFF_ABCD});
    tick("abc_c_in");
    chk("abc_out_c", 64'(bus.imm_ext_o), 64'h0000_0000_FFFF_FFFF);
    bus.in_valid_i = 1'b0;
    tick("abc_empty");
    chk("abc_drained", 64'(bus.out_valid_o), 64'd0);

    // Full-rate stream.
    begin
      int n0;
      n0 = n_out;
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, 2'($urandom_range(0, 2)), IMM_W'($urandom), 1'b1);
        tick("tput");
      end
      bus.in_valid_i = 1'b0;
      tick("tput_drain");
      chk("tput_count", 64'(n_out - n0), 64'd16);
    end

    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), IMM_W'($urandom), ($urandom % 3) != 0);
      tick("rand");
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (2) tick("rand_drain");

    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'b11, 20'h12345, 1'b1);
      tick("sat");
    end
    bus.in_valid_i = 1'b0;
    tick("sat_drain");
`ifndef IMM_EXT_SHIFT_MODE_EN
    chk("sat_cnt", 64'(bus.illegal_cnt_o), 64'hFF);
`endif

    // Asynchronous reset with the skid buffer full.
    drive(1'b1, 2'd0, 20'h00001, 1'b0);
    tick("rst_fill1");
    bus.imm_i = 20'h00002;
    tick("rst_fill2");
    bus.in_valid_i = 1'b0;
    chk("rst_skid_full", {62'b0, bus.in_ready_o, bus.out_valid_o}, {62'b0, 1'b0, 1'b1});
    #3 rst = 1'b1;
    #1;
    chk("async_rst",
        {21'b0, bus.out_valid_o, bus.illegal_o, bus.in_ready_o, bus.illegal_cnt_o, bus.imm_ext_o},
        {21'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0});
    mq.delete();
    mcnt = 0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 2'd1, 20'h0FFFF, 1'b1);
    tick("post_rst");
    bus.in_valid_i = 1'b0;
    tick("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
